psg_write_arbiter: RTL and testbench

Shares the single YM2149 (jt49) register write port between two requesters: the YM frame player, which streams registers 0–13 each vblank, and a CPU sound-effect channel fed by a small FIFO. CPU-programmed per-channel ownership lets effects take over tone channels A/B/C while the song keeps running underneath. The arbiter keeps a shadow copy of every music register. When a channel is released, it replays that channel's music state, so the song resumes cleanly. It sits between the music player and the jt49 instance.

---
 rtl/psg_write_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_psg_write_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/psg_write_arbiter.sv
// Arbitrates the single jt49 register write port between the YM frame player, a CPU
// sound-effect FIFO and a replay engine that restores a channel's music state on release.
module psg_write_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mus_req,
  input  logic [3:0] mus_addr,
  input  logic [7:0] mus_data,
  output logic       mus_ack,
  input  logic       sfx_wr,
  input  logic [3:0] sfx_addr,
  input  logic [7:0] sfx_data,
  output logic       sfx_full,
  input  logic [2:0] sfx_own,
  output logic [3:0] psg_addr,
  output logic [7:0] psg_data,
  output logic       psg_wr
);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_RESTORE} state_t;

  // Owned channels take their tone/noise enable bits (c and c+3) from the effect mixer.
  function automatic logic [7:0] mix_merge(input logic [7:0] mus, input logic [7:0] sfx,
                                           input logic [2:0] own);
    logic [7:0] m;
    m = {2'b00, own, own};
    return (mus & ~m) | (sfx & m);
  endfunction

  function automatic logic is_owned(input logic [3:0] a, input logic [2:0] own);
    case (a)
      4'd0, 4'd1, 4'd8:           return own[0];
      4'd2, 4'd3, 4'd9:           return own[1];
      4'd4, 4'd5, 4'd10:          return own[2];
      4'd6, 4'd11, 4'd12, 4'd13:  return |own;
      default:                    return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] restore_reg(input logic [1:0] ch, input logic [2:0] idx);
    case (idx)
      3'd0:    return {1'b0, ch, 1'b0};
      3'd1:    return {1'b0, ch, 1'b1};
      3'd2:    return 4'd8 + {2'b00, ch};
      3'd3:    return 4'd7;
      3'd4:    return 4'd6;
      3'd5:    return 4'd11;
      default: return 4'd12;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [1:0]    ch_q, ch_d;
  logic          rst_act_q, rst_act_d;
  logic [2:0]    pend_q, pend_d;
  logic [2:0]    own_q;
  logic [7:0]    sfx_mix_q, sfx_mix_d;
  logic [3:0]    psg_addr_q, psg_addr_d;
  logic [7:0]    psg_data_q, psg_data_d;
  logic          psg_wr_q, psg_wr_d;
  logic          mus_ack_q, mus_ack_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [11:0]   fifo_q [FIFO_DEPTH];
  logic [7:0]    mus_sh_q [16];

  logic          sh_we;
  logic          pop;
  logic          push_ok;
  logic          full;
  logic [2:0]    released, cur_mask, pend_eff;
  logic [1:0]    low_ch;
  logic [3:0]    rreg;
  logic [3:0]    head_addr;
  logic [7:0]    head_data;

  assign full      = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign push_ok   = sfx_wr & ~full;
  assign head_addr = fifo_q[rd_q][11:8];
  assign head_data = fifo_q[rd_q][7:0];
  assign released  = own_q & ~sfx_own;
  assign cur_mask  = rst_act_q ? (3'b001 << ch_q) : 3'b000;
  // Re-acquiring a channel cancels its replay unless that replay is already under way.
  assign pend_eff  = (pend_q | released) & ~(sfx_own & ~cur_mask);
  assign low_ch    = pend_eff[0] ? 2'd0 : (pend_eff[1] ? 2'd1 : 2'd2);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ch_d       = ch_q;
    rst_act_d  = rst_act_q;
    pend_d     = pend_eff;
    sfx_mix_d  = sfx_mix_q;
    psg_addr_d = psg_addr_q;
    psg_data_d = psg_data_q;
    psg_wr_d   = 1'b0;
    mus_ack_d  = 1'b0;
    sh_we      = 1'b0;
    pop        = 1'b0;
    rreg       = restore_reg(ch_q, idx_q);
    case (state_q)
      S_IDLE: begin
        if (|pend_eff) begin
          rreg       = restore_reg(low_ch, 3'd0);
          ch_d       = low_ch;
          idx_d      = 3'd0;
          rst_act_d  = 1'b1;
          psg_addr_d = rreg;
          psg_data_d = mus_sh_q[rreg];
          psg_wr_d   = 1'b1;
          state_d    = S_WRITE;
        end else if (cnt_q != '0) begin
          pop        = 1'b1;
          psg_addr_d = head_addr;
          psg_data_d = head_data;
          if (head_addr == 4'd7) begin
            sfx_mix_d  = head_data;
            psg_data_d = mix_merge(mus_sh_q[7], head_data, sfx_own);
          end
          psg_wr_d   = 1'b1;
          state_d    = S_WRITE;
        end else if (mus_req) begin
          sh_we     = 1'b1;
          mus_ack_d = 1'b1;
          state_d   = S_WRITE;
          if (!is_owned(mus_addr, sfx_own)) begin
            psg_wr_d   = 1'b1;
            psg_addr_d = mus_addr;
            psg_data_d = (mus_addr == 4'd7) ? mix_merge(mus_data, sfx_mix_q, sfx_own)
                                            : mus_data;
          end
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
        if (rst_act_q) begin
          // Shared registers are only replayed once no effect owns anything.
          if (idx_q == 3'd6 || (idx_q == 3'd3 && sfx_own != 3'b000)) begin
            rst_act_d = 1'b0;
            pend_d    = pend_eff & ~cur_mask;
          end else begin
            idx_d   = 3'(idx_q + 3'd1);
            state_d = S_RESTORE;
          end
        end
      end
      S_RESTORE: begin
        psg_addr_d = rreg;
        psg_data_d = (idx_q == 3'd3) ? mix_merge(mus_sh_q[7], sfx_mix_q, sfx_own)
                                     : mus_sh_q[rreg];
        psg_wr_d   = 1'b1;
        state_d    = S_WRITE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_d  = pop ? PW'(rd_q + 1'b1) : rd_q;
    wr_d  = push_ok ? PW'(wr_q + 1'b1) : wr_q;
    cnt_d = cnt_q;
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      ch_q       <= '0;
      rst_act_q  <= 1'b0;
      pend_q     <= '0;
      own_q      <= '0;
      sfx_mix_q  <= '0;
      psg_addr_q <= '0;
      psg_data_q <= '0;
      psg_wr_q   <= 1'b0;
      mus_ack_q  <= 1'b0;
      cnt_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      for (int i = 0; i < 16; i++) mus_sh_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ch_q       <= ch_d;
      rst_act_q  <= rst_act_d;
      pend_q     <= pend_d;
      own_q      <= sfx_own;
      sfx_mix_q  <= sfx_mix_d;
      psg_addr_q <= psg_addr_d;
      psg_data_q <= psg_data_d;
      psg_wr_q   <= psg_wr_d;
      mus_ack_q  <= mus_ack_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      if (sh_we) mus_sh_q[mus_addr] <= mus_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_q] <= {sfx_addr, sfx_data};
  end

  assign psg_addr = psg_addr_q;
  assign psg_data = psg_data_q;
  assign psg_wr   = psg_wr_q;
  assign mus_ack  = mus_ack_q;
  assign sfx_full = full;
endmodule

// File: tb/tb_psg_write_arbiter.sv
// Directed bench for psg_write_arbiter: music pass-through, ownership, mixer merge,
// channel release replay, grant priority, FIFO limits and mid-restore reset.
module tb_psg_write_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic       mus_req;
  logic [3:0] mus_addr;
  logic [7:0] mus_data;
  logic       mus_ack;
  logic       sfx_wr;
  logic [3:0] sfx_addr;
  logic [7:0] sfx_data;
  logic       sfx_full;
  logic [2:0] sfx_own;
  logic [3:0] psg_addr;
  logic [7:0] psg_data;
  logic       psg_wr;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [3:0] wq_a[$];
  logic [7:0] wq_d[$];
  int         ackq[$];

  psg_write_arbiter #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .mus_req(mus_req), .mus_addr(mus_addr), .mus_data(mus_data), .mus_ack(mus_ack),
    .sfx_wr(sfx_wr), .sfx_addr(sfx_addr), .sfx_data(sfx_data), .sfx_full(sfx_full),
    .sfx_own(sfx_own),
    .psg_addr(psg_addr), .psg_data(psg_data), .psg_wr(psg_wr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write/ack log sampled mid-cycle.
  always @(negedge clk) begin
    if (psg_wr) begin
      wq_a.push_back(psg_addr);
      wq_d.push_back(psg_data);
    end
    if (mus_ack) ackq.push_back(cyc);
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic clear_log();
    wq_a.delete();
    wq_d.delete();
    ackq.delete();
  endtask

  task automatic mus_write(input logic [3:0] a, input logic [7:0] d);
    int n;
    mus_req = 1'b1; mus_addr = a; mus_data = d; n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mus_ack && n < 60);
    mus_req = 1'b0;
    vectors++;
    if (mus_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL mus_ack_wait addr=%0d: got %b want 1", a, mus_ack);
    end
  endtask

  task automatic sfx_push(input logic [3:0] a, input logic [7:0] d);
    sfx_wr = 1'b1; sfx_addr = a; sfx_data = d;
    @(negedge clk);
    sfx_wr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    vectors += 5;
    if (psg_wr !== 1'b0)   begin miscompares++; $display("FAIL reset_psg_wr got %b want 0", psg_wr); end
    if (psg_addr !== 4'h0) begin miscompares++; $display("FAIL reset_psg_addr got %h want 0", psg_addr); end
    if (psg_data !== 8'h0) begin miscompares++; $display("FAIL reset_psg_data got %h want 0", psg_data); end
    if (mus_ack !== 1'b0)  begin miscompares++; $display("FAIL reset_mus_ack got %b want 0", mus_ack); end
    if (sfx_full !== 1'b0) begin miscompares++; $display("FAIL reset_sfx_full got %b want 0", sfx_full); end
    reset = 1'b0;
  endtask

  task automatic test_music_frame();
    clear_log();
    sfx_own = 3'b000;
    for (int i = 0; i < 14; i++) mus_write(4'(i), 8'(8'h10 + i));
    idle(3);
    vectors++;
    if (wq_a.size() != 14) begin
      miscompares++; $display("FAIL frame_count got %0d want 14", wq_a.size());
    end
    for (int i = 0; i < 14 && i < wq_a.size(); i++) begin
      vectors++;
      if (wq_a[i] !== 4'(i) || wq_d[i] !== 8'(8'h10 + i)) begin
        miscompares++;
        $display("FAIL frame_write[%0d] got %0d/%h want %0d/%h", i, wq_a[i], wq_d[i], i, 8'(8'h10 + i));
      end
    end
    for (int i = 1; i < ackq.size(); i++) begin
      vectors++;
      if (ackq[i] - ackq[i-1] != 2) begin
        miscompares++; $display("FAIL frame_ack_spacing[%0d] got %0d want 2", i, ackq[i] - ackq[i-1]);
      end
    end
  endtask

  task automatic test_ownership();
    sfx_own = 3'b001;
    idle(2);
    clear_log();
    mus_write(4'd0, 8'h55);
    mus_write(4'd8, 8'h0F);
    mus_write(4'd2, 8'h33);
    idle(3);
    vectors += 2;
    if (wq_a.size() != 1) begin
      miscompares++; $display("FAIL own_write_count got %0d want 1", wq_a.size());
    end
    if (wq_a.size() > 0 && (wq_a[0] !== 4'd2 || wq_d[0] !== 8'h33)) begin
      miscompares++; $display("FAIL own_reg2 got %0d/%h want 2/33", wq_a[0], wq_d[0]);
    end
  endtask

  task automatic test_release();
    logic [3:0] ea[7];
    logic [7:0] ed[7];
    ea = '{4'd0, 4'd1, 4'd8, 4'd7, 4'd6, 4'd11, 4'd12};
    ed = '{8'hAA, 8'h01, 8'h0C, 8'h17, 8'h10, 8'h20, 8'h00};
    mus_write(4'd0, 8'hAA);
    mus_write(4'd1, 8'h01);
    mus_write(4'd8, 8'h0C);
    mus_write(4'd6, 8'h10);
    mus_write(4'd11, 8'h20);
    mus_write(4'd12, 8'h00);
    idle(2);
    clear_log();
    sfx_own = 3'b000;
    idle(30);
    vectors++;
    if (wq_a.size() != 7) begin
      miscompares++; $display("FAIL release_count got %0d want 7", wq_a.size());
    end
    for (int i = 0; i < 7 && i < wq_a.size(); i++) begin
      vectors++;
      if (wq_a[i] !== ea[i] || wq_d[i] !== ed[i]) begin
        miscompares++;
        $display("FAIL release_write[%0d] got %0d/%h want %0d/%h", i, wq_a[i], wq_d[i], ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_mixer();
    logic [7:0] ed[3];
    ed = '{8'h38, 8'h39, 8'h09};
    clear_log();
    mus_write(4'd7, 8'h38);
    sfx_own = 3'b001;
    idle(2);
    sfx_push(4'd7, 8'h3F);
    idle(5);
    mus_write(4'd7, 8'h00);
    idle(3);
    vectors++;
    if (wq_a.size() != 3) begin
      miscompares++; $display("FAIL mixer_count got %0d want 3", wq_a.size());
    end
    for (int i = 0; i < 3 && i < wq_a.size(); i++) begin
      vectors++;
      if (wq_a[i] !== 4'd7 || wq_d[i] !== ed[i]) begin
        miscompares++;
        $display("FAIL mixer_write[%0d] got %0d/%h want 7/%h", i, wq_a[i], wq_d[i], ed[i]);
      end
    end
  endtask

  task automatic test_priority();
    logic [3:0] ea[10];
    logic [7:0] ed[10];
    int n;
    ea = '{4'd0, 4'd1, 4'd8, 4'd7, 4'd6, 4'd11, 4'd12, 4'd5, 4'd9, 4'd3};
    ed = '{8'hAA, 8'h01, 8'h0C, 8'h00, 8'h10, 8'h20, 8'h00, 8'h66, 8'h77, 8'h44};
    clear_log();
    sfx_own = 3'b000;
    mus_req = 1'b1; mus_addr = 4'd3; mus_data = 8'h44;
    sfx_push(4'd5, 8'h66);
    sfx_push(4'd9, 8'h77);
    n = 0;
    while (!mus_ack && n < 60) begin @(negedge clk); n++; end
    mus_req = 1'b0;
    idle(3);
    vectors++;
    if (wq_a.size() != 10) begin
      miscompares++; $display("FAIL prio_count got %0d want 10", wq_a.size());
    end
    for (int i = 0; i < 10 && i < wq_a.size(); i++) begin
      vectors++;
      if (wq_a[i] !== ea[i] || wq_d[i] !== ed[i]) begin
        miscompares++;
        $display("FAIL prio_write[%0d] got %0d/%h want %0d/%h", i, wq_a[i], wq_d[i], ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_fifo_full();
    sfx_own = 3'b001;
    idle(2);
    clear_log();
    sfx_own = 3'b000;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) begin
        vectors++;
        if (sfx_full !== 1'b0) begin miscompares++; $display("FAIL fifo_full_after3 got %b want 0", sfx_full); end
      end
      if (k == 4) begin
        vectors++;
        if (sfx_full !== 1'b1) begin miscompares++; $display("FAIL fifo_full_after4 got %b want 1", sfx_full); end
      end
      sfx_push(4'd14, 8'(8'hA0 + k));
    end
    idle(40);
    vectors++;
    if (wq_a.size() != 11) begin
      miscompares++; $display("FAIL fifo_write_count got %0d want 11", wq_a.size());
    end
    for (int i = 0; i < 4 && (7 + i) < wq_a.size(); i++) begin
      vectors++;
      if (wq_a[7+i] !== 4'd14 || wq_d[7+i] !== 8'(8'hA0 + i)) begin
        miscompares++;
        $display("FAIL fifo_write[%0d] got %0d/%h want 14/%h", i, wq_a[7+i], wq_d[7+i], 8'(8'hA0 + i));
      end
    end
  endtask

  task automatic test_reset_mid_restore();
    int n;
    sfx_own = 3'b001;
    idle(2);
    sfx_own = 3'b000;
    for (int k = 0; k < 4; k++) sfx_push(4'd15, 8'(8'hC0 + k));
    vectors++;
    if (sfx_full !== 1'b1) begin miscompares++; $display("FAIL rst_pre_full got %b want 1", sfx_full); end
    n = 0;
    while (psg_wr && n < 4) begin @(negedge clk); n++; end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors += 2;
    if (psg_wr !== 1'b0)   begin miscompares++; $display("FAIL rst_mid_psg_wr got %b want 0", psg_wr); end
    if (sfx_full !== 1'b0) begin miscompares++; $display("FAIL rst_mid_sfx_full got %b want 0", sfx_full); end
    clear_log();
    idle(30);
    vectors++;
    if (wq_a.size() != 0) begin
      miscompares++; $display("FAIL rst_mid_writes_after got %0d want 0", wq_a.size());
    end
  endtask

  initial begin
    reset = 1'b1; mus_req = 1'b0; mus_addr = '0; mus_data = '0;
    sfx_wr = 1'b0; sfx_addr = '0; sfx_data = '0; sfx_own = '0;
    @(negedge clk);
    test_reset();
    test_music_frame();
    test_ownership();
    test_release();
    test_mixer();
    test_priority();
    test_fifo_full();
    test_reset_mid_restore();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
